// File: rtl/pipe_stage_skid.sv
// One pipeline stage between two valid/ready handshakes.
// SKID_EN=1 adds a second entry so that in_ready can come from a register.
module pipe_stage_skid #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 16,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam bit useSkid = (SKID_EN != 0);

    state_t state;
    entry_t head;
    entry_t skid;
    logic   outValidReg;
    logic   inReadyReg;
    logic   inXfer;
    logic   outXfer;
    entry_t inEntry;

    // Without the skid entry the stage can only accept when its head leaves this cycle.
    assign in_ready  = useSkid ? inReadyReg : (!outValidReg || out_ready);
    assign inXfer    = in_valid && in_ready;
    assign outXfer   = outValidReg && out_ready;
    assign inEntry   = {in_ctrl, in_data};

    assign out_valid = outValidReg;
    assign out_ctrl  = head.ctrl;
    assign out_data  = head.data;
    assign occupancy = state;

    // head.ctrl is cleared whenever the stage goes empty so a bubble carries no enables;
    // head.data is left alone so out_data keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            head        <= '0;
            skid        <= '0;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            head.ctrl   <= '0;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inXfer) begin
                        head        <= inEntry;
                        state       <= ONE;
                        outValidReg <= 1'b1;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        head <= inEntry;
                    end else if (inXfer && useSkid) begin
                        skid       <= inEntry;
                        state      <= FULL;
                        inReadyReg <= 1'b0;
                    end else if (outXfer) begin
                        head.ctrl   <= '0;
                        state       <= EMPTY;
                        outValidReg <= 1'b0;
                    end
                end
                FULL: begin
                    if (outXfer) begin
                        head       <= skid;
                        state      <= ONE;
                        inReadyReg <= 1'b1;
                    end
                end
                default: begin
                    head.ctrl   <= '0;
                    state       <= EMPTY;
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (operands, immediates, register indices).
REQ-002 Parameter CTRL_W, default 16, width of the control payload (write enables, ALU op, mux selects).
REQ-003 Parameter SKID_EN, default 1, 1 = two-entry skid buffer with registered in_ready, 0 = single register with combinational in_ready.
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous squash of all held entries (branch/hazard bubble).
REQ-007 in_valid  input  1  upstream stage presents a valid entry.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 in_data  input  DATA_W  upstream datapath payload.
REQ-011 out_valid  output  1  stage presents a valid entry downstream.
REQ-012 out_ready  input  1  downstream accepts an entry (0 = stall).
REQ-013 out_ctrl  output  CTRL_W  control payload of the head entry.
REQ-014 out_data  output  DATA_W  datapath payload of the head entry.
REQ-015 occupancy  output  2  number of valid entries held (0..2; 0..1 when SKID_EN=0).

Function
REQ-016 Input transfer SHALL occur when in_valid & in_ready; output transfer SHALL occur when out_valid & out_ready.
REQ-017 Latency SHALL be 1 cycle from input transfer into an empty stage to out_valid; sustained throughput SHALL be 1 entry/cycle while out_ready=1.
REQ-018 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush/rst.
REQ-019 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble deasserts every enable); out_data SHALL hold its last value when out_valid=0.
REQ-020 SKID_EN=1: state SHALL be one of EMPTY (occupancy 0), ONE (1), FULL (2); in_ready SHALL equal (state != FULL) and be driven from a register.
REQ-021 EMPTY: input transfer -> ONE with head loaded; otherwise stay EMPTY.
REQ-022 ONE: input and output transfer together -> head replaced by input, stay ONE; input only -> input stored in skid, FULL; output only -> EMPTY; neither -> hold.
REQ-023 FULL: in_ready=0; output transfer -> skid moves to head, ONE; otherwise hold both entries unchanged.
REQ-024 SKID_EN=0: in_ready SHALL equal (!out_valid | out_ready) combinationally; states limited to EMPTY/ONE with REQ-021/022 except ONE input-only SHALL NOT occur.
REQ-025 Head payload SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL, next cycle, give state EMPTY, occupancy 0, out_valid 0, out_ctrl 0, in_ready 1; flush SHALL override any same-cycle input or output transfer and the input entry of that cycle SHALL be discarded.
REQ-027 occupancy SHALL be derived from state, never from a separate counter that can diverge.

Reset
REQ-028 rst=1 SHALL, on the next edge, set state EMPTY, out_valid 0, out_ctrl 0, out_data 0, occupancy 0, in_ready 1 (SKID_EN=1); rst SHALL take priority over flush and all transfers, including mid-stall with FULL state.
REQ-029 After rst deasserts, first input transfer SHALL be accepted in that same cycle.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1 with in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuous, occupancy 1.
REQ-031 Stall: accept A=0x11, hold out_ready=0, present B=0x22 -> occupancy 2, in_ready 0 next cycle, out_data 0x11 held; release out_ready -> 0x11 then 0x22, in_ready 1 after first drain.
REQ-032 Flush: FULL state with in_valid=1 (C=0x33), flush=1 -> next cycle out_valid 0, out_ctrl 0, occupancy 0; C never appears at output.
REQ-033 Reset mid-operation: FULL state, rst=1 one cycle -> out_valid 0, out_ctrl 0, out_data 0, in_ready 1; rst and flush together -> identical result.
REQ-034 SKID_EN=0: out_ready=0 with head valid -> in_ready 0 same cycle; out_ready=1 with in_valid=1 -> head replaced next cycle, occupancy stays 1.
REQ-035 Random in_valid/out_ready (>=10k cycles, both SKID_EN values) -> scoreboard order match, no loss, occupancy never exceeds 2 (1).
